// File: rtl/wb_trace_probe.sv
// Register-writeback observer: shadow register file with NUM_PROBE bypassed probes and a DEPTH-entry FWFT trace FIFO.
// Optional feature macro: TRACE_TIMESTAMP_EN (stores a 16-bit cycle stamp per entry and exposes rd_ts).
module wb_trace_probe #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 16,
  parameter int NUM_PROBE = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_en,
  input  logic [ADDR_W-1:0]             wb_addr,
  input  logic [DATA_W-1:0]             wb_data,
  input  logic [NUM_PROBE*ADDR_W-1:0]   probe_sel,
  output logic [NUM_PROBE*DATA_W-1:0]   probe_data,
  input  logic                          wrap_mode,
  input  logic                          clr,
  input  logic                          rd_en,
  output logic                          rd_valid,
  output logic [ADDR_W-1:0]             rd_addr,
  output logic [DATA_W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
`ifdef TRACE_TIMESTAMP_EN
  output logic [15:0]                   rd_ts,
`endif
  output logic                          overflow
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0]           shadow_q   [NREG];
  logic [DATA_W-1:0]           shadow_d   [NREG];
  logic [NUM_PROBE*DATA_W-1:0] probe_q, probe_d;
  logic [ADDR_W-1:0]           mem_addr_q [DEPTH];
  logic [ADDR_W-1:0]           mem_addr_d [DEPTH];
  logic [DATA_W-1:0]           mem_data_q [DEPTH];
  logic [DATA_W-1:0]           mem_data_d [DEPTH];
  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]               rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        ovf_q, ovf_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [15:0]                 ts_q, ts_d;
  logic [15:0]                 mem_ts_q [DEPTH];
  logic [15:0]                 mem_ts_d [DEPTH];
`endif

  logic push, pop, is_full, wr_en;

  assign push    = wb_en && (wb_addr != '0);
  assign is_full = (count_q == CW'(DEPTH));
  assign pop     = rd_en && (count_q != '0);

  // Shadow file mirrors the CPU registers; probes bypass the same-cycle writeback.
  always_comb begin
    shadow_d = shadow_q;
    probe_d  = '0;
    if (push) shadow_d[wb_addr] = wb_data;
    for (int i = 0; i < NUM_PROBE; i++) begin
      if (push && (wb_addr == probe_sel[i*ADDR_W +: ADDR_W]))
        probe_d[i*DATA_W +: DATA_W] = wb_data;
      else
        probe_d[i*DATA_W +: DATA_W] = shadow_q[probe_sel[i*ADDR_W +: ADDR_W]];
    end
  end

  // When full, a lone push either drops or evicts the head by advancing both pointers.
  always_comb begin
    wr_en    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (!is_full) begin
      if (push) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end else if (push && pop) begin
      wr_en    = 1'b1;
      wr_ptr_d = wr_ptr_q + PW'(1);
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_q - CW'(1);
    end else if (push) begin
      ovf_d = 1'b1;
      if (wrap_mode) begin
        wr_en    = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_comb begin
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (wr_en) begin
      mem_addr_d[wr_ptr_q] = wb_addr;
      mem_data_d[wr_ptr_q] = wb_data;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  always_comb begin
    ts_d     = ts_q + 16'd1;
    mem_ts_d = mem_ts_q;
    if (wr_en) mem_ts_d[wr_ptr_q] = ts_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) shadow_q[r] <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        mem_addr_q[e] <= '0;
        mem_data_q[e] <= '0;
      end
      probe_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q   <= shadow_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      probe_q    <= probe_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef TRACE_TIMESTAMP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
      for (int e = 0; e < DEPTH; e++) mem_ts_q[e] <= '0;
    end else begin
      ts_q     <= ts_d;
      mem_ts_q <= mem_ts_d;
    end
  end

  assign rd_ts = rd_valid ? mem_ts_q[rd_ptr_q] : '0;
`endif

  assign rd_valid   = (count_q != '0);
  assign rd_addr    = rd_valid ? mem_addr_q[rd_ptr_q] : '0;
  assign rd_data    = rd_valid ? mem_data_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign full       = is_full;
  assign overflow   = ovf_q;
  assign probe_data = probe_q;

endmodule
